frame_writer: RTL and testbench



---
 rtl/img_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 58 +++++
 rtl/frame_writer.sv | 186 ++++++++++++++++++
 tb/tb_frame_writer.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/img_pkg.sv
// Shared pixel/word types and frame-writer state encoding for the pixel pipeline.
package img_pkg;

    localparam int PIX_W        = 4;
    localparam int WORD_W       = 16;
    localparam int PIX_PER_WORD = 4;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } fw_state_t;

    function automatic pixel_t binarize(input pixel_t p, input pixel_t t);
        return (p >= t) ? 4'hF : 4'h0;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-low reset; a push while full is
// accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    assign full      = (count_r == CNT_W'(DEPTH));
    assign empty     = (count_r == {CNT_W{1'b0}});
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign dout      = mem_r[rd_ptr_r];

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Packs a 4-bit pixel stream into 16-bit words and writes one frame to SRAM.
// Optional binarizing threshold input enabled by FRAME_WRITER_THRESH_EN.
module frame_writer
    import img_pkg::*;
#(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int ADDR_W     = 18,
    parameter int BASE_ADDR  = 0,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst_n,
`ifdef FRAME_WRITER_THRESH_EN
    input  logic [3:0]        thresh,
`endif
    input  logic              start,
    input  logic [3:0]        pixel_in,
    input  logic              in_valid,
    output logic              mem_req,
    input  logic              mem_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              busy,
    output logic              frame_done,
    output logic              overflow
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int ENT_W = ADDR_W + WORD_W;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(IMG_H - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    fw_state_t         state_r;
    fw_state_t         state_next_s;
    logic [COL_W-1:0]  col_r;
    logic [ROW_W-1:0]  row_r;
    logic [ADDR_W-1:0] addr_r;
    logic [11:0]       pack_r;
    logic              overflow_r;
    logic              busy_r;
    logic              frame_done_r;
    logic              mem_req_r;
    logic [ADDR_W-1:0] mem_addr_r;
    word_t             mem_wdata_r;

    pixel_t            pix_s;
    word_t             word_s;
    logic              pix_take_s;
    logic              word_done_s;
    logic              last_pix_s;
    logic              pop_s;
    logic              drop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [ENT_W-1:0]  fifo_dout_s;

`ifdef FRAME_WRITER_THRESH_EN
    assign pix_s = binarize(pixel_in, thresh);
`else
    assign pix_s = pixel_in;
`endif

    assign pix_take_s  = (state_r == CAPTURE) && in_valid;
    assign word_done_s = pix_take_s && (col_r[1:0] == 2'd3);
    assign last_pix_s  = pix_take_s && (col_r == COL_LAST) && (row_r == ROW_LAST);
    assign word_s      = {pix_s, pack_r};
    assign pop_s       = !mem_req_r && !fifo_empty_s;
    // A completed word is lost only when the FIFO cannot make room this cycle.
    assign drop_s      = word_done_s && fifo_full_s && !pop_s;

    sync_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (word_done_s),
        .din   ({addr_r, word_s}),
        .pop   (pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s)
    );

    // Next-state logic for the frame sequencer.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (start) state_next_s = CAPTURE;
                else       state_next_s = IDLE;
            end
            CAPTURE: begin
                if (last_pix_s) state_next_s = DRAIN;
                else            state_next_s = CAPTURE;
            end
            DRAIN: begin
                if (fifo_empty_s && !mem_req_r) state_next_s = DONE;
                else                            state_next_s = DRAIN;
            end
            DONE:    state_next_s = IDLE;
            default: state_next_s = IDLE;
        endcase
    end

    // State register with registered busy/frame_done decoded from next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            busy_r       <= (state_next_s == CAPTURE) || (state_next_s == DRAIN);
            frame_done_r <= (state_next_s == DONE);
        end
    end

    // Pixel counters, pack register, word address counter and overflow flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            col_r      <= {COL_W{1'b0}};
            row_r      <= {ROW_W{1'b0}};
            addr_r     <= BASE;
            pack_r     <= 12'h000;
            overflow_r <= 1'b0;
        end else if ((state_r == IDLE) && start) begin
            col_r      <= {COL_W{1'b0}};
            row_r      <= {ROW_W{1'b0}};
            addr_r     <= BASE;
            pack_r     <= 12'h000;
            overflow_r <= 1'b0;
        end else if (pix_take_s) begin
            case (col_r[1:0])
                2'd0:    pack_r[3:0]  <= pix_s;
                2'd1:    pack_r[7:4]  <= pix_s;
                2'd2:    pack_r[11:8] <= pix_s;
                default: pack_r       <= pack_r;
            endcase
            if (col_r == COL_LAST) begin
                col_r <= {COL_W{1'b0}};
                row_r <= (row_r == ROW_LAST) ? {ROW_W{1'b0}} : row_r + ROW_W'(1);
            end else begin
                col_r <= col_r + COL_W'(1);
            end
            // Address advances even for a dropped word so later words stay in place.
            if (word_done_s) begin
                addr_r <= addr_r + ADDR_W'(1);
            end
            if (drop_s) begin
                overflow_r <= 1'b1;
            end
        end else begin
            pack_r <= pack_r;
        end
    end

    // SRAM write port: load from FIFO head when idle, hold until acknowledged.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_req_r   <= 1'b0;
            mem_addr_r  <= BASE;
            mem_wdata_r <= 16'h0000;
        end else if (pop_s) begin
            mem_req_r   <= 1'b1;
            mem_addr_r  <= fifo_dout_s[ENT_W-1:WORD_W];
            mem_wdata_r <= fifo_dout_s[WORD_W-1:0];
        end else if (mem_req_r && mem_ack) begin
            mem_req_r <= 1'b0;
        end else begin
            mem_req_r <= mem_req_r;
        end
    end

    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign mem_wdata  = mem_wdata_r;
    assign busy       = busy_r;
    assign frame_done = frame_done_r;
    assign overflow   = overflow_r;

endmodule

// File: tb/tb_frame_writer.sv
// Directed self-checking bench for frame_writer on an 8x2 frame at base 0x100.
// A 2-entry FIFO lets a single stalled 4-word frame drop its last word.
module tb_frame_writer;

    localparam int IMG_W  = 8;
    localparam int IMG_H  = 2;
    localparam int ADDR_W = 18;
    localparam int BASE   = 'h100;
    localparam int DEPTH  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              start;
    logic [3:0]        pixel_in;
    logic              in_valid;
    logic              mem_req;
    logic              mem_ack;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              busy;
    logic              frame_done;
    logic              overflow;
`ifdef FRAME_WRITER_THRESH_EN
    logic [3:0]        thresh;
`endif

    int checks = 0;
    int errors = 0;
    int ack_mode = 0;

    logic [ADDR_W-1:0] wr_addr [64];
    logic [15:0]       wr_data [64];
    int wr_cnt   = 0;
    int done_cnt = 0;
    int req_cnt  = 0;

    logic [3:0]        pix_tab [16];
    logic [ADDR_W-1:0] exp_addr [4];
    logic [15:0]       exp_data [4];

    frame_writer #(
        .IMG_W      (IMG_W),
        .IMG_H      (IMG_H),
        .ADDR_W     (ADDR_W),
        .BASE_ADDR  (BASE),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef FRAME_WRITER_THRESH_EN
        .thresh     (thresh),
`endif
        .start      (start),
        .pixel_in   (pixel_in),
        .in_valid   (in_valid),
        .mem_req    (mem_req),
        .mem_ack    (mem_ack),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy),
        .frame_done (frame_done),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Record completed writes, done pulses and request cycles mid-cycle.
    always @(negedge clk) begin
        if (rst_n && mem_req && mem_ack && (wr_cnt < 64)) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = mem_wdata;
            wr_cnt = wr_cnt + 1;
        end
        if (frame_done) done_cnt = done_cnt + 1;
        if (mem_req) req_cnt = req_cnt + 1;
    end

    // Memory-side acknowledge: 0 = always, 1 = never, other = random.
    initial begin
        mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            case (ack_mode)
                0:       mem_ack = 1'b1;
                1:       mem_ack = 1'b0;
                default: mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        if (obs !== exp) begin
            errors = errors + 1;
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_frame(input int gap);
        for (int i = 0; i < 16; i++) begin
            pixel_in = pix_tab[i];
            in_valid = 1'b1;
            tick();
            if (gap != 0) begin
                pixel_in = 4'hA;
                in_valid = 1'b0;
                tick();
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int dbase, input int max_cyc);
        int n;
        n = 0;
        while ((done_cnt == dbase) && (n < max_cyc)) begin
            tick();
            n = n + 1;
        end
        chk({tag, "_done_seen"}, 32'(done_cnt > dbase), 32'd1);
    endtask

    task automatic check_image(input string tag, input int base, input int n);
        chk({tag, "_wr_count"}, 32'(wr_cnt - base), 32'(n));
        for (int i = 0; i < n; i++) begin
            if (base + i < 64) begin
                chk($sformatf("%s_addr%0d", tag, i), 32'(wr_addr[base + i]), 32'(exp_addr[i]));
                chk($sformatf("%s_data%0d", tag, i), 32'(wr_data[base + i]), 32'(exp_data[i]));
            end
        end
    endtask

    initial begin
        int base;
        int dbase;
        int rbase;

        for (int i = 0; i < 16; i++) pix_tab[i] = 4'(i + 1);
        exp_addr[0] = 18'h00100; exp_data[0] = 16'h4321;
        exp_addr[1] = 18'h00101; exp_data[1] = 16'h8765;
        exp_addr[2] = 18'h00102; exp_data[2] = 16'hCBA9;
        exp_addr[3] = 18'h00103; exp_data[3] = 16'h0FED;

        rst_n    = 1'b0;
        start    = 1'b0;
        pixel_in = 4'h0;
        in_valid = 1'b0;
`ifdef FRAME_WRITER_THRESH_EN
        thresh   = 4'h8;
`endif
        ack_mode = 0;
        repeat (3) tick();
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'h100);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_frame_done", 32'(frame_done), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        rst_n = 1'b1;
        tick();

`ifdef FRAME_WRITER_THRESH_EN
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        for (int i = 0; i < 16; i++) pix_tab[i] = 4'h0;
        pix_tab[0] = 4'h7; pix_tab[1] = 4'h8; pix_tab[2] = 4'h9; pix_tab[3] = 4'h0;
        send_frame(0);
        wait_done("thr", dbase, 60);
        chk("thr_wr_count", 32'(wr_cnt - base), 32'd4);
        chk("thr_addr0", 32'(wr_addr[base]), 32'h100);
        chk("thr_data0", 32'(wr_data[base]), 32'h0FF0);
        chk("thr_addr1", 32'(wr_addr[base + 1]), 32'h101);
        chk("thr_data1", 32'(wr_data[base + 1]), 32'h0000);
`else
        // Basic frame with ack tied high.
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        chk("s1_busy_capture", 32'(busy), 32'd1);
        send_frame(0);
        wait_done("s1", dbase, 60);
        repeat (3) tick();
        check_image("s1", base, 4);
        chk("s1_done_once", 32'(done_cnt - dbase), 32'd1);
        chk("s1_busy_end", 32'(busy), 32'd0);
        chk("s1_overflow", 32'(overflow), 32'd0);

        // Stalled memory: first word held, last word dropped.
        ack_mode = 1;
        tick();
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        send_frame(0);
        repeat (4) tick();
        chk("st_req_held", 32'(mem_req), 32'd1);
        chk("st_addr_held", 32'(mem_addr), 32'h100);
        chk("st_data_held", 32'(mem_wdata), 32'h4321);
        chk("st_overflow", 32'(overflow), 32'd1);
        chk("st_no_write", 32'(wr_cnt - base), 32'd0);
        ack_mode = 0;
        wait_done("st", dbase, 60);
        repeat (3) tick();
        check_image("st", base, 3);
        chk("st_overflow_sticky", 32'(overflow), 32'd1);

        // Gapped input with random acknowledge.
        ack_mode = 2;
        tick();
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        chk("gp_overflow_clr", 32'(overflow), 32'd0);
        send_frame(1);
        wait_done("gp", dbase, 200);
        repeat (10) tick();
        check_image("gp", base, 4);
        chk("gp_done_once", 32'(done_cnt - dbase), 32'd1);

        // Pixels in IDLE and start pulses during CAPTURE are ignored.
        ack_mode = 0;
        tick();
        rbase = req_cnt;
        for (int i = 0; i < 8; i++) begin
            pixel_in = 4'h5;
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        repeat (4) tick();
        chk("ig_no_req", 32'(req_cnt - rbase), 32'd0);
        chk("ig_busy", 32'(busy), 32'd0);
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            pixel_in = pix_tab[i];
            in_valid = 1'b1;
            start    = ((i == 2) || (i == 9)) ? 1'b1 : 1'b0;
            tick();
        end
        in_valid = 1'b0;
        start    = 1'b0;
        wait_done("ig", dbase, 60);
        repeat (3) tick();
        check_image("ig", base, 4);
        chk("ig_done_once", 32'(done_cnt - dbase), 32'd1);

        // Reset mid-frame with a request outstanding.
        ack_mode = 1;
        tick();
        dbase = done_cnt;
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            pixel_in = pix_tab[i];
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        chk("mr_req_pending", 32'(mem_req), 32'd1);
        rst_n = 1'b0;
        tick();
        chk("mr_req_dropped", 32'(mem_req), 32'd0);
        chk("mr_busy", 32'(busy), 32'd0);
        rst_n    = 1'b1;
        ack_mode = 0;
        tick();
        chk("mr_no_done", 32'(done_cnt - dbase), 32'd0);
        base  = wr_cnt;
        dbase = done_cnt;
        pulse_start();
        send_frame(0);
        wait_done("mr", dbase, 60);
        repeat (3) tick();
        check_image("mr", base, 4);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
